// File: rtl/neuron_mac.sv
// Streaming multiply-accumulate for one neuron pre-activation: z = bias + sum(x[i]*w[i]).
// Q8.24 signed operands, guarded accumulator, saturated registered output with a valid pulse.
//
// state | meaning
// IDLE  | waiting for start; clears out_valid after an emitted result
// ACCUM | accepting N_IN x/w pairs into the accumulator
// EMIT  | saturating the sum onto y and pulsing out_valid
module neuron_mac #(
   parameter int WIDTH = 32,
   parameter int FL    = 24,
   parameter int N_IN  = 4,
   parameter int GUARD = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    start,
   input  logic signed [WIDTH-1:0] bias,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] w_in,
   output logic                    busy,
   output logic        [WIDTH-1:0] y,
   output logic                    out_valid
);

   localparam int AW = WIDTH + GUARD;
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(N_IN) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N_IN - 1);
   localparam logic signed [AW-1:0] ACC_MAX = {{(GUARD + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [AW-1:0] ACC_MIN = {{(GUARD + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic signed [AW-1:0]    acc;
   logic        [CW-1:0]    cnt;
   logic signed [PW-1:0]    prod_full;
   logic signed [WIDTH-1:0] prod;
   logic        [WIDTH-1:0] sat_val;
   logic                    unused_prod;

   // Floor toward -inf: just drop the low FL bits of the full product.
   assign prod_full   = PW'(x_in) * PW'(w_in);
   assign prod        = prod_full[FL+WIDTH-1:FL];
   assign unused_prod = ^{prod_full[PW-1:FL+WIDTH], prod_full[FL-1:0]};

   assign busy = (state != IDLE);

   always_comb begin
      sat_val = acc[WIDTH-1:0];
      if (acc > ACC_MAX) begin
         sat_val = {1'b0, {(WIDTH - 1){1'b1}}};
      end else if (acc < ACC_MIN) begin
         sat_val = {1'b1, {(WIDTH - 1){1'b0}}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else if (en) begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = ACCUM;
         ACCUM:   if (in_valid && (cnt == CNT_LAST)) state_nxt = EMIT;
         EMIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         y         <= '0;
         out_valid <= 1'b0;
      end else if (en) begin
         case (state)
            IDLE: begin
               out_valid <= 1'b0;
               if (start) begin
                  acc <= AW'(bias);
                  cnt <= '0;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc <= acc + AW'(prod);
                  // wrap to zero on the last pair so cnt stays within 0..N_IN-1
                  cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
               end
            end
            EMIT: begin
               y         <= sat_val;
               out_valid <= 1'b1;
            end
            default: out_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized and directed bench for neuron_mac with a queue scoreboard and a decoupled
// output monitor; expected sums come from a plain 64-bit arithmetic model.
module tb_neuron_mac;

   localparam int NIN = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        start;
   logic [31:0] bias;
   logic        in_valid;
   logic [31:0] x_in;
   logic [31:0] w_in;
   logic        busy;
   logic [31:0] y;
   logic        out_valid;

   int          checks = 0;
   int          fails  = 0;
   int          cyc    = 0;
   logic [31:0] sb[$];
   int          pulse_cyc[$];
   bit          ov_prev = 1'b0;
   bit          en_prev = 1'b0;
   logic signed [31:0] xs[NIN];
   logic signed [31:0] ws[NIN];

   neuron_mac #(.WIDTH(32), .FL(24), .N_IN(NIN), .GUARD(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .start    (start),
      .bias     (bias),
      .in_valid (in_valid),
      .x_in     (x_in),
      .w_in     (w_in),
      .busy     (busy),
      .y        (y),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      en_prev = en;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: bias + sum of floor(x*w / 2^24) wrapped to 32 bits, then clamped to int32.
   function automatic logic [31:0] model(input logic signed [31:0] b);
      longint s;
      longint pr;
      s = longint'(b);
      for (int i = 0; i < NIN; i++) begin
         pr = longint'(xs[i]) * longint'(ws[i]);
         s += longint'(int'(pr >>> 24));
      end
      if (s > 64'sh7FFFFFFF) return 32'h7FFFFFFF;
      if (s < -64'sh80000000) return 32'h80000000;
      return s[31:0];
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !ov_prev) begin
            pulse_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_out: got y=%h expected no output (cycle %0d)", y, cyc);
            end else begin
               check("y", y, sb.pop_front());
            end
         end
         if (ov_prev && en_prev) check("ov_width", {31'b0, out_valid}, 32'd0);
      end
      ov_prev = out_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] x, input logic [31:0] w);
      for (int i = 0; i < NIN; i++) begin
         xs[i] = x;
         ws[i] = w;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NIN; i++) begin
         xs[i] = 32'($urandom_range(0, 32'h0FFFFFFF)) - 32'h08000000;
         ws[i] = 32'($urandom_range(0, 32'h0FFFFFFF)) - 32'h08000000;
      end
   endtask

   task automatic begin_neuron(input logic [31:0] b);
      bias  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      bias  = $urandom;
      check("busy_after_start", {31'b0, busy}, 32'd1);
   endtask

   task automatic pair(input logic [31:0] x, input logic [31:0] w);
      in_valid = 1'b1;
      x_in     = x;
      w_in     = w;
      tick();
      in_valid = 1'b0;
      x_in     = $urandom;
      w_in     = $urandom;
   endtask

   // gap < 0 selects a random 0..2 idle cycles before each pair
   task automatic run_pairs(input int first, input int last, input int gap);
      int g;
      for (int i = first; i <= last; i++) begin
         g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
         for (int j = 0; j < g; j++) begin
            tick();
            check("ov_quiet_gap", {31'b0, out_valid}, 32'd0);
         end
         pair(xs[i], ws[i]);
      end
   endtask

   task automatic finish_neuron();
      check("busy_in_emit", {31'b0, busy}, 32'd1);
      check("ov_early", {31'b0, out_valid}, 32'd0);
      tick();
      check("ov_latency", {31'b0, out_valid}, 32'd1);
      check("busy_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b;
      rst      = 1'b1;
      en       = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      bias     = '0;
      x_in     = '0;
      w_in     = '0;
      tick();
      tick();
      check("rst_y", y, 32'd0);
      check("rst_ov", {31'b0, out_valid}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      // basic sum: 0.5 + 4 * (1.0 * 0.25)
      fill(32'h01000000, 32'h00400000);
      sb.push_back(model(32'h00800000));
      begin_neuron(32'h00800000);
      run_pairs(0, NIN - 1, 0);
      finish_neuron();
      tick();
      check("ov_one_cycle", {31'b0, out_valid}, 32'd0);

      // gapped stream, floor truncation of tiny negative products
      fill(32'h00800000, 32'hFFFFFFFF);
      sb.push_back(model(32'h00000000));
      begin_neuron(32'h00000000);
      run_pairs(0, NIN - 1, 2);
      finish_neuron();
      tick();

      // positive and negative saturation
      fill(32'h10000000, 32'h04000000);
      sb.push_back(model(32'h7F000000));
      begin_neuron(32'h7F000000);
      run_pairs(0, NIN - 1, 0);
      finish_neuron();
      tick();
      fill(32'h10000000, 32'hFC000000);
      sb.push_back(model(32'h81000000));
      begin_neuron(32'h81000000);
      run_pairs(0, NIN - 1, 0);
      finish_neuron();
      tick();

      // enable freeze mid-accumulation and while out_valid is high
      fill(32'h01000000, 32'h00400000);
      sb.push_back(model(32'h00800000));
      begin_neuron(32'h00800000);
      run_pairs(0, 1, 0);
      en       = 1'b0;
      in_valid = 1'b1;
      start    = 1'b1;
      bias     = 32'h12345678;
      x_in     = 32'h02000000;
      w_in     = 32'h02000000;
      repeat (5) tick();
      check("busy_frozen", {31'b0, busy}, 32'd1);
      en       = 1'b1;
      in_valid = 1'b0;
      start    = 1'b0;
      run_pairs(2, NIN - 1, 0);
      finish_neuron();
      en = 1'b0;
      repeat (3) tick();
      check("ov_stretch", {31'b0, out_valid}, 32'd1);
      en = 1'b1;
      tick();
      check("ov_clear", {31'b0, out_valid}, 32'd0);

      // reset mid-accumulation discards the partial sum
      fill_random();
      begin_neuron($urandom);
      run_pairs(0, 2, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_y", y, 32'd0);
      check("midrst_ov", {31'b0, out_valid}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      repeat (3) tick();

      // in_valid in IDLE and start in ACCUM are both ignored
      fill_random();
      b = $urandom;
      in_valid = 1'b1;
      x_in     = 32'h01000000;
      w_in     = 32'h01000000;
      tick();
      tick();
      in_valid = 1'b0;
      sb.push_back(model(b));
      begin_neuron(b);
      run_pairs(0, 1, 0);
      start = 1'b1;
      bias  = b ^ 32'h40000000;
      tick();
      start = 1'b0;
      run_pairs(2, NIN - 1, 0);
      finish_neuron();
      tick();

      // back-to-back: second start issued during the out_valid cycle
      fill_random();
      b = $urandom;
      sb.push_back(model(b));
      begin_neuron(b);
      run_pairs(0, NIN - 1, 0);
      finish_neuron();
      fill_random();
      b = $urandom;
      sb.push_back(model(b));
      begin_neuron(b);
      run_pairs(0, NIN - 1, 0);
      finish_neuron();
      tick();
      if (pulse_cyc.size() < 2) begin
         checks++;
         fails++;
         $display("FAIL b2b_period: got %0d pulses expected at least 2", pulse_cyc.size());
      end else begin
         check("b2b_period", 32'(pulse_cyc[$] - pulse_cyc[$-1]), 32'(NIN + 2));
      end

      // randomized neurons with random gaps and IDLE noise
      for (int n = 0; n < 16; n++) begin
         fill_random();
         b = $urandom;
         sb.push_back(model(b));
         begin_neuron(b);
         run_pairs(0, NIN - 1, -1);
         finish_neuron();
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'($urandom);
            x_in     = $urandom;
            w_in     = $urandom;
            tick();
         end
         in_valid = 1'b0;
      end

      tick();
      tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage that forms one neuron pre-activation z = bias + sum(x[i]*w[i]) over N_IN streamed input/weight pairs.
- All values are signed fixed point Q8.24.
- Sits directly upstream of the sigmoid activation stage; its y/out_valid output feeds the activation's data input.
- One pair is accepted per cycle when in_valid is high; gaps are allowed.

Parameters:
- WIDTH, 32, data word width (signed two's complement).
- FL, 24, fractional bits of the fixed-point format.
- N_IN, 4, number of input/weight pairs per neuron (>=1).
- GUARD, 8, extra integer guard bits in the internal accumulator.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  global clock enable; when low, all state and outputs hold.
- start  input  1  begin a new neuron; sampled only in IDLE.
- bias  input  WIDTH  signed Q8.24 bias, sampled on the accepted start.
- in_valid  input  1  x_in/w_in carry a valid pair this cycle.
- x_in  input  WIDTH  signed Q8.24 activation sample.
- w_in  input  WIDTH  signed Q8.24 weight sample.
- busy  output  1  high whenever state != IDLE (decoded from the state register).
- y  output  WIDTH  signed Q8.24 saturated pre-activation, registered.
- out_valid  output  1  one-cycle pulse marking a new y.

Behaviour:
- Reset (rst=1 at a clock edge, regardless of en):
  - state=IDLE, acc=0, cnt=0, y=0, out_valid=0, busy=0.
  - A reset mid-accumulation discards the partial sum; no out_valid is issued.
- en=0: no register changes (state, acc, cnt, y, out_valid all hold); inputs are ignored. rst still has priority over en.
- FSM states: IDLE, ACCUM, EMIT. All transitions below require en=1.
  - IDLE:
    - out_valid<=0.
    - If start: acc<=sign-extend(bias) to WIDTH+GUARD, cnt<=0, go to ACCUM.
    - in_valid in IDLE is ignored.
  - ACCUM:
    - If in_valid: acc<=acc+sign-extend(p), cnt<=cnt+1.
    - If in_valid and cnt==N_IN-1: go to EMIT.
    - in_valid=0: hold, no timeout.
    - start is ignored.
  - EMIT: y<=sat(acc), out_valid<=1, go to IDLE. start is ignored in EMIT.
- Product p:
  - Full 2*WIDTH signed product x_in*w_in.
  - Take bits [FL+WIDTH-1:FL], i.e. an arithmetic shift right by FL (floor toward -inf, no rounding), truncated to WIDTH bits.
  - Operands are bounded so products fit in Q8.24; overflow of an individual product wraps and is not detected.
- Accumulator: WIDTH+GUARD bits signed; it cannot overflow for N_IN <= 2^(GUARD-1).
- sat(acc):
  - acc > 0x7FFFFFFF -> 0x7FFFFFFF.
  - acc < -0x80000000 -> 0x80000000.
  - Otherwise acc[WIDTH-1:0].
- Latency:
  - Last pair accepted at edge E; y and out_valid=1 are updated at edge E+1.
  - out_valid clears at edge E+2, unless en=0, which stretches it.
  - y holds until the next EMIT or reset.
- Back-to-back: start may be asserted in the cycle out_valid=1 (state is already IDLE). Minimum period per neuron is N_IN+2 cycles.
- busy: 1 in ACCUM and EMIT, 0 in IDLE.
- N_IN=1: a single accepted pair moves ACCUM to EMIT directly.
- cnt width is clog2(N_IN)+1; cnt never exceeds N_IN-1.

Test Plan:
- Basic sum:
  - Stimulus: start with bias=0x00800000 (0.5); four consecutive pairs x=0x01000000 (1.0), w=0x00400000 (0.25).
  - Required: y=0x01800000 (1.5) with out_valid high for exactly 1 cycle, 1 cycle after the 4th pair; busy high from the cycle after start until the edge that sets out_valid.
- Gapped stream and floor truncation:
  - Stimulus: bias=0; four pairs x=0x00800000, w=0xFFFFFFFF, with in_valid low for 2 cycles between each pair.
  - Required: each product is 0xFFFFFFFF (floor), final y=0xFFFFFFFC; out_valid only after the 4th valid pair.
- Saturation:
  - Positive case: bias=0x7F000000, four pairs x=0x10000000, w=0x04000000 (64.0 each) -> y=0x7FFFFFFF.
  - Negative case: bias=0x81000000, same x, w=0xFC000000 -> y=0x80000000.
- Enable freeze:
  - Stimulus: drop en for 5 cycles after the 2nd pair, driving in_valid=1 and start=1 during the freeze.
  - Required: no pairs are counted during the freeze; the result equals the basic-sum case once the remaining 2 pairs arrive; an out_valid asserted while en=0 stays high until en returns.
- Reset mid-operation and ignored controls:
  - Stimulus: assert rst after 3 pairs.
  - Required: next cycle y=0, out_valid=0, busy=0.
  - Also: a start pulse in ACCUM does not reload the bias; in_valid in IDLE does not change the next result.
- Back-to-back neurons: start asserted in the out_valid cycle gives two correct results separated by exactly N_IN+2 cycles.
